// File: rtl/imm_pack_pkg.sv
// rtl/imm_pack_pkg.sv - shared encodings and widths for the immediate packer
package imm_pack_pkg;

  localparam int IMM_DATA_W = 16;
  localparam int SPLIT_W    = 8;
  localparam int IMM_W12    = 12;
  localparam int IMM_W10    = 10;

  localparam logic IMM_SEL_12 = 1'b0;
  localparam logic IMM_SEL_10 = 1'b1;

  typedef enum logic [1:0] {
    IMM_IDLE = 2'd0,
    IMM_ONE  = 2'd1,
    IMM_HI   = 2'd2,
    IMM_LO   = 2'd3
  } imm_state_t;

endpackage

// File: rtl/imm_pack_if.sv
// rtl/imm_pack_if.sv - constant-in / encoded-field-out handshake bundle
interface imm_pack_if;
  import imm_pack_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_DATA_W-1:0] in_value;
  logic                  in_imSlct;

  logic                  out_valid;
  logic                  out_ready;
  logic [IMM_DATA_W-1:0] out_field;
  logic                  out_hi;
  logic                  out_last;
  logic                  out_fits;

  modport master (
    output in_valid, in_value, in_imSlct, out_ready,
    input  in_ready, out_valid, out_field, out_hi, out_last, out_fits
  );

  modport slave (
    input  in_valid, in_value, in_imSlct, out_ready,
    output in_ready, out_valid, out_field, out_hi, out_last, out_fits
  );

endinterface

// File: rtl/imm_fit_check.sv
// rtl/imm_fit_check.sv - does a 16-bit constant fit the selected signed immediate field
module imm_fit_check
  import imm_pack_pkg::*;
(
  input  logic [IMM_DATA_W-1:0] value,
  input  logic                  sel,
  output logic                  fit
);

  logic fits12;
  logic fits10;

  // A value fits an N-bit signed field when bits [15:N-1] are all copies of the sign.
  assign fits12 = (&value[IMM_DATA_W-1:IMM_W12-1]) | ~(|value[IMM_DATA_W-1:IMM_W12-1]);
  assign fits10 = (&value[IMM_DATA_W-1:IMM_W10-1]) | ~(|value[IMM_DATA_W-1:IMM_W10-1]);
  assign fit    = (sel == IMM_SEL_12) ? fits12 : fits10;

endmodule

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - encode a 16-bit constant as one immediate beat or a hi/lo split
// Optional IMM_PACK_STATS_EN adds saturating stat_total / stat_split counters.
module imm_pack #(
  parameter int DATA_W  = 16,
  parameter int SPLIT_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  imm_pack_if.slave         bus
`ifdef IMM_PACK_STATS_EN
  ,
  output logic [15:0]       stat_split,
  output logic [15:0]       stat_total
`endif
);

  import imm_pack_pkg::*;

  imm_state_t        state;
  imm_state_t        state_n;
  logic [DATA_W-1:0] v_q;
  logic              sel_q;
  logic              fit;
  logic              take;

  imm_fit_check u_fit (
    .value (bus.in_value),
    .sel   (bus.in_imSlct),
    .fit   (fit)
  );

  assign take = bus.in_valid && (state == IMM_IDLE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IMM_IDLE;
      v_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        v_q   <= bus.in_value;
        sel_q <= bus.in_imSlct;
      end
    end
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_field = '0;
    bus.out_hi    = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_fits  = 1'b0;
    case (state)
      IMM_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = fit ? IMM_ONE : IMM_HI;
      end
      IMM_ONE: begin
        bus.out_valid = 1'b1;
        bus.out_fits  = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_field = (sel_q == IMM_SEL_10)
                      ? {{(DATA_W-IMM_W10){1'b0}}, v_q[IMM_W10-1:0]}
                      : {{(DATA_W-IMM_W12){1'b0}}, v_q[IMM_W12-1:0]};
        if (bus.out_ready) state_n = IMM_IDLE;
      end
      IMM_HI: begin
        bus.out_valid = 1'b1;
        bus.out_hi    = 1'b1;
        bus.out_field = {{SPLIT_W{1'b0}}, v_q[DATA_W-1:SPLIT_W]};
        if (bus.out_ready) state_n = IMM_LO;
      end
      IMM_LO: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_field = {{(DATA_W-SPLIT_W){1'b0}}, v_q[SPLIT_W-1:0]};
        if (bus.out_ready) state_n = IMM_IDLE;
      end
      default: state_n = IMM_IDLE;
    endcase
  end

`ifdef IMM_PACK_STATS_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stat_total <= '0;
      stat_split <= '0;
    end else if (take) begin
      if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
      if (!fit && stat_split != 16'hFFFF) stat_split <= stat_split + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - self-checking bench for imm_pack
module tb_imm_pack;

  logic CLK;
  logic reset;
  int   n_pass;
  int   n_total;

  imm_pack_if bus ();

`ifdef IMM_PACK_STATS_EN
  logic [15:0] stat_split;
  logic [15:0] stat_total;
`endif

  imm_pack dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
`ifdef IMM_PACK_STATS_EN
    ,
    .stat_split (stat_split),
    .stat_total (stat_total)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] val;
    logic        sel;
    int          stall;
    int          nb;
    logic [15:0] f0;
    logic [15:0] f1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] f, input logic hi,
                          input logic last, input logic fits);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".field"}, 32'(bus.out_field), 32'(f));
    chk({tag, ".hi"},    32'(bus.out_hi),    32'(hi));
    chk({tag, ".last"},  32'(bus.out_last),  32'(last));
    chk({tag, ".fits"},  32'(bus.out_fits),  32'(fits));
    chk({tag, ".in_ready_low"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Behavioural reference: range test on the signed value, then byte split.
  function automatic void model(input logic [15:0] val, input logic sel, output int nb,
                                output logic [15:0] f0, output logic [15:0] f1);
    int sv  = int'($signed(val));
    int lim = sel ? 512 : 2048;
    if (sv >= -lim && sv < lim) begin
      nb = 1;
      f0 = 16'(int'(val) % (2 * lim));
      f1 = 16'd0;
    end else begin
      nb = 2;
      f0 = 16'(int'(val) / 256);
      f1 = 16'(int'(val) % 256);
    end
  endfunction

  task automatic xfer(input string tag, input logic [15:0] val, input logic sel, input int stall,
                      input int nb, input logic [15:0] f0, input logic [15:0] f1);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    bus.in_value  = val;
    bus.in_imSlct = sel;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    bus.in_value  = 16'($urandom);
    bus.in_imSlct = 1'($urandom);
    for (int b = 0; b < nb; b++) begin
      logic [15:0] f    = (b == 0) ? f0 : f1;
      logic        hi   = (nb == 2) && (b == 0);
      logic        last = (b == nb - 1);
      logic        fits = (nb == 1);
      for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
        bus.out_ready = 1'b0;
        chk_beat($sformatf("%s.b%0d.stall%0d", tag, b, s), f, hi, last, fits);
        @(negedge CLK);
      end
      bus.out_ready = 1'b1;
      chk_beat($sformatf("%s.b%0d", tag, b), f, hi, last, fits);
      @(negedge CLK);
      bus.out_ready = 1'b0;
    end
    chk({tag, ".done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int          nb;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [15:0] val;
    logic        sel;
    logic [15:0] bounds[4];

    n_pass = 0;
    n_total = 0;
    bus.in_valid  = 1'b0;
    bus.in_value  = 16'h0;
    bus.in_imSlct = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;

    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_field", 32'(bus.out_field), 32'd0);
    chk("rst.out_hi",    32'(bus.out_hi),    32'd0);
    chk("rst.out_last",  32'(bus.out_last),  32'd0);
    chk("rst.out_fits",  32'(bus.out_fits),  32'd0);

    vecs.push_back('{"fit12_max",  16'h07FF, 1'b0, 0, 1, 16'h07FF, 16'h0000});
    vecs.push_back('{"fit12_min",  16'hF800, 1'b0, 0, 1, 16'h0800, 16'h0000});
    vecs.push_back('{"split12_p",  16'h0800, 1'b0, 0, 2, 16'h0008, 16'h0000});
    vecs.push_back('{"split12_n",  16'hF7FF, 1'b0, 1, 2, 16'h00F7, 16'h00FF});
    vecs.push_back('{"fit10_max",  16'h01FF, 1'b1, 0, 1, 16'h01FF, 16'h0000});
    vecs.push_back('{"fit10_min",  16'hFE00, 1'b1, 0, 1, 16'h0200, 16'h0000});
    vecs.push_back('{"split10_p",  16'h0200, 1'b1, 0, 2, 16'h0002, 16'h0000});
    vecs.push_back('{"split10_n",  16'hFDFF, 1'b1, 2, 2, 16'h00FD, 16'h00FF});
    vecs.push_back('{"zero",       16'h0000, 1'b0, 0, 1, 16'h0000, 16'h0000});
    vecs.push_back('{"ones10",     16'hFFFF, 1'b1, 0, 1, 16'h03FF, 16'h0000});
    vecs.push_back('{"ones12",     16'hFFFF, 1'b0, 0, 1, 16'h0FFF, 16'h0000});
    vecs.push_back('{"stall_hi",   16'h1234, 1'b1, 5, 2, 16'h0012, 16'h0034});
    foreach (vecs[i])
      xfer(vecs[i].name, vecs[i].val, vecs[i].sel, vecs[i].stall, vecs[i].nb, vecs[i].f0, vecs[i].f1);

    // Reset while the HI beat of 0xABCD is pending drops the LO beat.
    bus.in_value  = 16'hABCD;
    bus.in_imSlct = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    chk_beat("midrst.hi", 16'h00AB, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst.out_field", 32'(bus.out_field), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("midrst.no_lo", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    xfer("after_rst", 16'h0005, 1'b0, 0, 1, 16'h0005, 16'h0000);

    bounds[0] = 16'h0800;
    bounds[1] = 16'hF800;
    bounds[2] = 16'h0200;
    bounds[3] = 16'hFE00;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       val = 16'($urandom);
        1:       val = bounds[$urandom_range(0, 3)] + 16'($urandom_range(0, 4)) - 16'd2;
        default: val = 16'($urandom_range(0, 1023)) - 16'd512;
      endcase
      sel = 1'($urandom);
      model(val, sel, nb, f0, f1);
      xfer($sformatf("rnd%0d", i), val, sel, $urandom_range(0, 2), nb, f0, f1);
    end

`ifdef IMM_PACK_STATS_EN
    do_reset();
    chk("stat.rst_total", 32'(stat_total), 32'd0);
    chk("stat.rst_split", 32'(stat_split), 32'd0);
    bounds[0] = 16'h0001;
    bounds[1] = 16'h0800;
    bounds[2] = 16'hFFFF;
    bounds[3] = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      model(bounds[i], 1'b0, nb, f0, f1);
      xfer($sformatf("stat%0d", i), bounds[i], 1'b0, 0, nb, f0, f1);
    end
    chk("stat.total", 32'(stat_total), 32'd4);
    chk("stat.split", 32'(stat_split), 32'd2);
`else
    do_reset();
    chk("final_rst.in_ready", 32'(bus.in_ready), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
Inverse of the immediate sign-extension path: takes a full 16-bit constant and encodes it into the instruction immediate field.
- imSlct=0 selects the 12-bit signed field; imSlct=1 selects the 10-bit signed field.
- If the constant is representable in the selected field, one beat is emitted.
- Otherwise a two-beat split is emitted: high byte (lui-style), then low byte (ori-style).
- Sits between the constant source (assembler/loader or test sequencer) and instruction word assembly. Valid/ready on both sides.

Parameters:
- DATA_W, 16, constant width; only 16 is supported.
- SPLIT_W, 8, width of the low part in a split; the high part is DATA_W-SPLIT_W.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  constant offered.
- in_ready  output  1  block can accept a constant.
- in_value  input  16  constant to encode.
- in_imSlct  input  1  0 = 12-bit field, 1 = 10-bit field.
- out_valid  output  1  out_field valid.
- out_ready  input  1  consumer accepts the beat.
- out_field  output  16  encoded field, right-aligned, unused upper bits zero.
- out_hi  output  1  current beat is the high part of a split.
- out_last  output  1  final beat of this constant.
- out_fits  output  1  constant fit the selected field (single-beat encoding).

Behaviour:
- Fit rules:
  - fits12 = in_value[15:11] all equal.
  - fits10 = in_value[15:9] all equal.
  - fit = in_imSlct ? fits10 : fits12.
- States: IDLE, ONE, HI, LO (2-bit encoding).
- in_ready = 1 only in IDLE. A transfer occurs when in_valid && in_ready.
- IDLE + transfer:
  - Register in_value and imSlct.
  - Next state is ONE if fit, else HI.
  - out_valid rises on the following cycle (1-cycle latency; no combinational in->out path).
- ONE:
  - out_field = imSlct ? {6'b0, v[9:0]} : {4'b0, v[11:0]}.
  - out_fits=1, out_hi=0, out_last=1.
  - On out_ready go to IDLE.
- HI:
  - out_field = {8'b0, v[15:8]}.
  - out_fits=0, out_hi=1, out_last=0.
  - On out_ready go to LO.
- LO:
  - out_field = {8'b0, v[7:0]}, zero-extended.
  - out_fits=0, out_hi=0, out_last=1.
  - On out_ready go to IDLE.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and the state does not advance.
- out_valid = 1 in ONE, HI and LO; 0 in IDLE.
- Throughput:
  - 1 constant per 2 cycles when it fits.
  - 1 constant per 3 cycles when it is split.
  - No input acceptance during a beat.
- Boundaries:
  - 0x07FF / 0xF800 fit 12; 0x0800 / 0xF7FF split.
  - 0x01FF / 0xFE00 fit 10; 0x0200 / 0xFDFF split.
  - 0x0000 and 0xFFFF always fit.
- Reset:
  - state=IDLE; out_valid, out_field, out_hi, out_last, out_fits = 0.
  - in_ready reads 1 in the first cycle after reset deasserts.
  - Reset mid-transaction (ONE/HI/LO) drops the constant; no remaining beat is emitted.
- in_value and in_imSlct changes outside a transfer are ignored.

Optional Feature:
- Macro IMM_PACK_STATS_EN.
- Defined:
  - Extra outputs stat_split[15:0] and stat_total[15:0].
  - Incremented on each input transfer (split: stat_split and stat_total; fit: stat_total only).
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - State encodings IMM_IDLE=0, IMM_ONE=1, IMM_HI=2, IMM_LO=3.
  - Field widths IMM_W12=12, IMM_W10=10.
  - IMM_SEL_12=0, IMM_SEL_10=1.
  - SPLIT_W.
- One natural sub-module: imm_fit_check (combinational fit detection from value and select), reusable by the assembler checker.

Test Plan:
- 0x07FF, imSlct=0, out_ready=1 -> one beat: out_field=0x07FF, fits=1, last=1, out_valid high exactly 1 cycle after the transfer.
- 0x0800, imSlct=0 -> HI beat 0x0008 (hi=1, last=0), then LO beat 0x0000 (last=1); in_ready low for both beats.
- 0xFE00, imSlct=1 -> single beat 0x0200, fits=1. 0x0200, imSlct=1 -> HI 0x0002, then LO 0x0000.
- 0x1234, imSlct=1, out_ready held low 5 cycles during HI -> out_field=0x0012 stable throughout; then LO 0x0034; in_ready returns only after LO is accepted.
- Reset asserted for 1 cycle in HI for 0xABCD -> out_valid=0 next cycle, no LO beat, in_ready=1; next input 0x0005 (imSlct=0) -> single beat 0x0005.
- With IMM_PACK_STATS_EN: inputs 0x0001, 0x0800, 0xFFFF, 0x4000 (imSlct=0) -> stat_total=4, stat_split=2.
